// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_pkg
// Brief    : Shared types and size helpers for the pixel stream sink.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

  // Receiver state: collecting pixels, or holding a completed frame
  typedef enum logic [0:0] {
    RECV = 1'b0,
    FULL = 1'b1
  } sink_state_t;

  typedef logic [7:0]  pixel_t;
  typedef logic [15:0] checksum_t;

  // Number of pixels in one frame
  function automatic int calc_pixels(input int width, input int height);
    return width * height;
  endfunction

  // Address width for a buffer of the given depth (never below 1 bit)
  function automatic int calc_addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_ram.sv
`default_nettype none
// ============================================================================
// Module   : frame_ram
// Brief    : DEPTH x 8 frame buffer, one synchronous write port and one
//            registered read port with read-before-write behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module frame_ram
  import pixel_stream_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  pixel_t                wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output pixel_t                rd_data
);

  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage is deliberately not reset so the array maps onto block RAM
  pixel_t r_mem [DEPTH];

  logic w_rd_in_range;
  assign w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH);

  // Write port: store the accepted pixel
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered, sees the pre-write contents on an address clash
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (w_rd_in_range) begin
      rd_data <= r_mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_sink
// Brief    : Valid/ready pixel stream sink. Captures one raster-order frame
//            into a buffer, keeps a running checksum, and holds the producer
//            off until the consumer acknowledges the completed frame.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_frame_sink
  import pixel_stream_pkg::*;
#(
  parameter  int IMG_WIDTH  = 4,
  parameter  int IMG_HEIGHT = 4,
  localparam int IMG_PIXELS = calc_pixels(IMG_WIDTH, IMG_HEIGHT),
  localparam int ADDR_WIDTH = calc_addr_width(IMG_PIXELS),
  localparam int COL_WIDTH  = $clog2(IMG_WIDTH),
  localparam int ROW_WIDTH  = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            pixel_in,
  input  logic                  pixel_valid_in,
  output logic                  pixel_ready_out,
  output logic                  frame_done,
  input  logic                  frame_ack,
  output logic [COL_WIDTH-1:0]  wr_col,
  output logic [ROW_WIDTH-1:0]  wr_row,
  output logic [15:0]           checksum,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_PTR = ADDR_WIDTH'(IMG_PIXELS - 1);
  localparam logic [COL_WIDTH-1:0]  c_LAST_COL = COL_WIDTH'(IMG_WIDTH - 1);

  sink_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [COL_WIDTH-1:0]  r_wr_col;
  logic [ROW_WIDTH-1:0]  r_wr_row;
  checksum_t             r_checksum;
  logic                  r_frame_done;
  logic                  w_transfer;

  // Ready depends only on state, and drops at once while reset is held
  assign pixel_ready_out = (r_state == RECV) && !rst;
  assign w_transfer      = pixel_valid_in && pixel_ready_out;

  assign frame_done = r_frame_done;
  assign wr_col     = r_wr_col;
  assign wr_row     = r_wr_row;
  assign checksum   = r_checksum;

  // Receive FSM with write position, checksum and frame-done flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RECV;
      r_wr_ptr     <= '0;
      r_wr_col     <= '0;
      r_wr_row     <= '0;
      r_checksum   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        RECV: begin
          // A late ack in this state is meaningless and is ignored
          if (w_transfer) begin
            r_checksum <= r_checksum + {8'h00, pixel_in};
            if (r_wr_ptr == c_LAST_PTR) begin
              r_wr_ptr     <= '0;
              r_wr_col     <= '0;
              r_wr_row     <= '0;
              r_state      <= FULL;
              r_frame_done <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              if (r_wr_col == c_LAST_COL) begin
                r_wr_col <= '0;
                r_wr_row <= r_wr_row + 1'b1;
              end else begin
                r_wr_col <= r_wr_col + 1'b1;
              end
            end
          end
        end
        FULL: begin
          // Buffer and checksum stay frozen until the consumer releases them
          if (frame_ack) begin
            r_state      <= RECV;
            r_checksum   <= '0;
            r_frame_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= RECV;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

  frame_ram #(
    .DEPTH      (IMG_PIXELS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_frame_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_transfer),
    .wr_addr (r_wr_ptr),
    .wr_data (pixel_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_frame_sink
// Brief    : Directed self-checking bench for pixel_frame_sink (4x4 frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_sink;

  logic        clk;
  logic        rst;
  logic [7:0]  pixel_in;
  logic        pixel_valid_in;
  logic        pixel_ready_out;
  logic        frame_done;
  logic        frame_ack;
  logic [1:0]  wr_col;
  logic [1:0]  wr_row;
  logic [15:0] checksum;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;

  int n_assert;
  int n_fail;

  pixel_frame_sink #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pixel_in        (pixel_in),
    .pixel_valid_in  (pixel_valid_in),
    .pixel_ready_out (pixel_ready_out),
    .frame_done      (frame_done),
    .frame_ack       (frame_ack),
    .wr_col          (wr_col),
    .wr_row          (wr_row),
    .checksum        (checksum),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Read one buffer location: address set at a negedge, data one edge later
  task automatic chk_read(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    @(negedge clk);
    chk(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  // Pulse ack in FULL and confirm the release
  task automatic do_ack();
    pixel_valid_in = 1'b0;
    frame_ack      = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("ack_ready", {31'h0, pixel_ready_out}, 32'h1);
    chk("ack_done", {31'h0, frame_done}, 32'h0);
    chk("ack_csum", {16'h0, checksum}, 32'h0);
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    pixel_in       = 8'h00;
    pixel_valid_in = 1'b0;
    frame_ack      = 1'b0;
    rd_addr        = 4'h0;

    // ---- Reset state ----
    @(negedge clk);
    chk("rst_ready", {31'h0, pixel_ready_out}, 32'h0);
    chk("rst_done", {31'h0, frame_done}, 32'h0);
    chk("rst_csum", {16'h0, checksum}, 32'h0);
    chk("rst_pos", {28'h0, wr_row, wr_col}, 32'h0);
    chk("rst_rdata", {24'h0, rd_data}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'h0, pixel_ready_out}, 32'h1);

    // ---- Frame fill 0x00..0x0F, ack in RECV at i=3 and on final edge ----
    for (int i = 0; i < 16; i++) begin
      chk("f1_col", {30'h0, wr_col}, i % 4);
      chk("f1_row", {30'h0, wr_row}, i / 4);
      chk("f1_ready", {31'h0, pixel_ready_out}, 32'h1);
      pixel_valid_in = 1'b1;
      pixel_in       = 8'(i);
      frame_ack      = (i == 3) || (i == 15);
      @(negedge clk);
    end
    frame_ack      = 1'b0;
    pixel_valid_in = 1'b0;
    chk("f1_done", {31'h0, frame_done}, 32'h1);
    chk("f1_ready_lo", {31'h0, pixel_ready_out}, 32'h0);
    chk("f1_csum", {16'h0, checksum}, 32'h0078);
    chk("f1_pos_wrap", {28'h0, wr_row, wr_col}, 32'h0);
    @(negedge clk);
    chk("f1_done_hold", {31'h0, frame_done}, 32'h1);
    chk_read("f1_rd5", 4'd5, 8'h05);
    chk_read("f1_rd15", 4'd15, 8'h0F);
    chk_read("f1_rd3", 4'd3, 8'h03);

    // ---- Backpressure: valid held with 0xAA in FULL ----
    pixel_valid_in = 1'b1;
    pixel_in       = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready", {31'h0, pixel_ready_out}, 32'h0);
    end
    chk("bp_csum", {16'h0, checksum}, 32'h0078);
    chk("bp_done", {31'h0, frame_done}, 32'h1);
    chk_read("bp_rd0", 4'd0, 8'h00);
    chk_read("bp_rd15", 4'd15, 8'h0F);
    do_ack();

    // ---- Second frame: 16 x 0xFF ----
    for (int i = 0; i < 16; i++) begin
      chk("f2_col", {30'h0, wr_col}, i % 4);
      chk("f2_row", {30'h0, wr_row}, i / 4);
      pixel_valid_in = 1'b1;
      pixel_in       = 8'hFF;
      @(negedge clk);
    end
    pixel_valid_in = 1'b0;
    chk("f2_done", {31'h0, frame_done}, 32'h1);
    chk("f2_csum", {16'h0, checksum}, 32'h0FF0);
    chk("f2_pos_wrap", {28'h0, wr_row, wr_col}, 32'h0);
    for (int k = 0; k < 16; k++) begin
      chk_read("f2_rd", 4'(k), 8'hFF);
    end
    do_ack();

    // ---- Bubbles: valid every other cycle, 0x10..0x1F ----
    for (int i = 0; i < 16; i++) begin
      pixel_valid_in = 1'b1;
      pixel_in       = 8'h10 + 8'(i);
      @(negedge clk);
      pixel_valid_in = 1'b0;
      pixel_in       = 8'hEE;
      if (i == 14) begin
        chk("bub_done_early", {31'h0, frame_done}, 32'h0);
        chk("bub_pos", {28'h0, wr_row, wr_col}, 32'hF);
      end
      @(negedge clk);
    end
    chk("bub_done", {31'h0, frame_done}, 32'h1);
    chk("bub_csum", {16'h0, checksum}, 32'h0178);
    for (int k = 0; k < 16; k++) begin
      chk_read("bub_rd", 4'(k), 8'h10 + 8'(k));
    end
    do_ack();

    // ---- Reset mid-frame after 7 transfers of 0x01 ----
    for (int i = 0; i < 7; i++) begin
      pixel_valid_in = 1'b1;
      pixel_in       = 8'h01;
      @(negedge clk);
    end
    pixel_valid_in = 1'b0;
    chk("mid_csum", {16'h0, checksum}, 32'h0007);
    chk("mid_pos", {28'h0, wr_row, wr_col}, 32'h7);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_ready", {31'h0, pixel_ready_out}, 32'h0);
    chk("mr_done", {31'h0, frame_done}, 32'h0);
    chk("mr_csum", {16'h0, checksum}, 32'h0);
    chk("mr_pos", {28'h0, wr_row, wr_col}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pixel_valid_in = 1'b1;
      pixel_in       = 8'h02;
      @(negedge clk);
    end
    pixel_valid_in = 1'b0;
    chk("mr_f_done", {31'h0, frame_done}, 32'h1);
    chk("mr_f_csum", {16'h0, checksum}, 32'h0020);
    chk_read("mr_rd0", 4'd0, 8'h02);
    chk_read("mr_rd15", 4'd15, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
